bcd_share_scheduler: RTL and testbench
======================================

Name: bcd_share_scheduler

Overview:
- Shares one combinational 14-bit binary-to-BCD converter (4 digits) between two requesters: A, the current Collatz value, and B, the step count.
- Per request, the block clamps the value, presents it to the converter, waits for settling, captures the four BCD digits into that source's digit register, and acks.
- It also scans a 4-digit multiplexed seven-segment display from the digit register of the selected source.
- Sits between the Collatz datapath and the board display driver.

Parameters:
- CONV_WAIT, 1, cycles `bcd_in` is held before capture (converter settle time), legal range 1..15.
- REFRESH_DIV, 50000, clocks per digit slot (1 kHz per digit at 50 MHz), minimum 2.
- BLANK, 1, 1 = blank leading zero digits; the ones digit is never blanked.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- a_val  in  14  source A binary value.
- a_req  in  1  A request, level; held until a_ack.
- a_ack  out  1  one-cycle pulse; A digits captured.
- b_val  in  14  source B binary value.
- b_req  in  1  B request, level.
- b_ack  out  1  one-cycle pulse; B digits captured.
- disp_sel  in  1  0 = display A, 1 = display B.
- bcd_in  out  14  registered operand to the shared converter.
- cv_ones, cv_tens, cv_hundreds, cv_thousands  in  4 each  converter outputs.
- busy  out  1  high while not IDLE.
- ovf  out  1  overflow flag of the displayed source.
- an  out  4  active-low digit anodes.
- digit  out  4  BCD nibble for the active anode.

Behaviour:
- Reset values: all outputs 0 except `an` = 4'b1111. State = IDLE. Both digit registers = 0, both ovf flags = 0. Round-robin pointer favours A. Refresh counter = 0, scan index = 0.
- FSM states and transitions:
  - IDLE: if any request is pending, grant it.
    - Only one request pending: grant that one.
    - Both pending: grant the source the pointer favours; the pointer then flips to favour the other source.
    - On grant: register bcd_in = min(val, 9999), record the granted source, latch ovf_src = (val > 9999), load wait counter = CONV_WAIT, go to CONV.
  - CONV: decrement the wait counter; go to CAPT when it reaches 1. bcd_in is held stable throughout.
  - CAPT, one cycle: the granted source's ack = 1; capture {cv_thousands, cv_hundreds, cv_tens, cv_ones} and ovf_src into that source's registers at the end of the cycle; return to IDLE.
- Latency with CONV_WAIT = 1:
  - req sampled at edge t.
  - ack high during cycle t+2.
  - new digits visible on the scan from cycle t+3.
  - In general, ack occurs CONV_WAIT+1 cycles after the grant edge.
- A request still high during the ack cycle is ignored; a request still high in IDLE afterwards is a new request. Under sustained requests from both sources, grants strictly alternate A, B, A, ...
- The value is sampled only at the grant edge. Changes to val during CONV or CAPT are ignored.
- Digit scan (runs independently of the FSM):
  - The refresh counter wraps at REFRESH_DIV-1; on wrap the scan index increments modulo 4 (3 -> 0).
  - an = ~(1 << idx); digit = nibble idx of the register selected by disp_sel. Both are registered, one cycle behind idx/disp_sel.
  - Blanking (BLANK = 1): digit k (k > 0) is blanked when nibbles k..3 are all zero. A blanked digit drives an = 4'b1111 and digit = 0.
  - A disp_sel change is reflected in digit and ovf on the next clock, with no restart of the scan.
- Capture while a digit is displayed: the new nibble appears on the next clock; no tearing guard is required.
- rst asserted mid-operation: returns to the reset state immediately at that edge. No ack is issued for the aborted request, and the digit registers clear.

Decomposition:
- Shared package `bcd_share_pkg`: FSM state encoding (IDLE, CONV, CAPT), NUM_DIGITS = 4, BCD_MAX = 14'd9999, VAL_W = 14.
- One sub-module `digit_scan`: refresh counter, scan index, anode decode and blanking. Ports: clk, rst, a 16-bit digit word in, an and digit out.
- The converter itself is instantiated at top level, not inside this block.

Test Plan:
- Reset: rst high 2 cycles -> an = 1111, digit = 0, busy = 0, a_ack = b_ack = 0, bcd_in = 0.
- Single A request: a_val = 1234 pulsed with a_req -> bcd_in = 1234; a_ack one cycle at t+2; with disp_sel = 0, scan shows 4, 3, 2, 1 on anode idx 0..3; ovf = 0.
- Simultaneous requests: a_req = b_req = 1 held, a_val = 5, b_val = 77 -> a_ack, then b_ack 3 cycles later, then a_ack again; digit registers A = 0005, B = 0077.
- Clamp: b_val = 12000 -> bcd_in = 9999; B digits 9, 9, 9, 9; with disp_sel = 1, ovf = 1.
- Blanking (REFRESH_DIV = 2): A = 7 displayed -> only idx 0 asserts an = 1110 with digit 7; idx 1..3 give an = 1111; with BLANK = 0, all four anodes fire and idx 1..3 show 0.
- Reset mid-conversion (CONV_WAIT = 4): assert rst during CONV -> no a_ack ever; busy = 0; digit registers read 0.

Source files
------------

// File: rtl/bcd_share_pkg.sv
// Shared types and constants for the BCD converter share scheduler.
// Clamp limit, digit count and FSM encoding used by the top and the scan.
package bcd_share_pkg;

    localparam int unsigned VAL_W      = 14;
    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned WORD_W     = 4 * NUM_DIGITS;

    localparam logic [VAL_W-1:0] BCD_MAX = 14'd9999;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        CAPT = 2'd2
    } state_t;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_t;

    // Saturate a binary value to the largest 4-digit BCD number.
    function automatic logic [VAL_W-1:0] clamp_val(input logic [VAL_W-1:0] v);
        return (v > BCD_MAX) ? BCD_MAX : v;
    endfunction

endpackage

// File: rtl/digit_scan.sv
// Multiplexed 4-digit seven-segment scan: refresh divider, scan index,
// active-low anode decode and leading-zero blanking.
module digit_scan
    import bcd_share_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned BLANK       = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] word,
    output logic [3:0]        an,
    output logic [3:0]        digit
);

    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic [3:0]       nib;
    logic             blank_c;
    logic [3:0]       one_hot;

    // A digit is blanked only when it and every more significant nibble are zero.
    always_comb begin
        nib     = word[{idx, 2'b00} +: 4];
        one_hot = 4'b0001 << idx;
        blank_c = (BLANK != 0) && (idx != 2'd0) &&
                  ((word >> {idx, 2'b00}) == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            idx   <= 2'd0;
            an    <= 4'b1111;
            digit <= 4'd0;
        end else begin
            if (cnt == CNT_W'(REFRESH_DIV - 1)) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            an    <= blank_c ? 4'b1111 : ~one_hot;
            digit <= blank_c ? 4'd0 : nib;
        end
    end

endmodule

// File: rtl/bcd_share_scheduler.sv
// Round-robin sharing of one binary-to-BCD converter between two requesters,
// with per-source digit registers feeding a multiplexed display scan.
module bcd_share_scheduler
    import bcd_share_pkg::*;
#(
    parameter int unsigned CONV_WAIT   = 1,
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned BLANK       = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [VAL_W-1:0] a_val,
    input  logic             a_req,
    output logic             a_ack,
    input  logic [VAL_W-1:0] b_val,
    input  logic             b_req,
    output logic             b_ack,
    input  logic             disp_sel,
    output logic [VAL_W-1:0] bcd_in,
    input  logic [3:0]       cv_ones,
    input  logic [3:0]       cv_tens,
    input  logic [3:0]       cv_hundreds,
    input  logic [3:0]       cv_thousands,
    output logic             busy,
    output logic             ovf,
    output logic [3:0]       an,
    output logic [3:0]       digit
);

    state_t            state;
    src_t              src;
    logic [3:0]        wait_cnt;
    logic              rr_b;
    logic              ovf_src;
    logic [WORD_W-1:0] dig_a;
    logic [WORD_W-1:0] dig_b;
    logic              ovf_a;
    logic              ovf_b;
    logic              grant_b;
    logic [VAL_W-1:0]  sel_val;
    logic [WORD_W-1:0] show_word;

    // B wins when it is the only requester or when the pointer favours it.
    always_comb begin
        grant_b   = b_req && (!a_req || rr_b);
        sel_val   = grant_b ? b_val : a_val;
        show_word = disp_sel ? dig_b : dig_a;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            src      <= SRC_A;
            wait_cnt <= 4'd0;
            rr_b     <= 1'b0;
            ovf_src  <= 1'b0;
            dig_a    <= '0;
            dig_b    <= '0;
            ovf_a    <= 1'b0;
            ovf_b    <= 1'b0;
            bcd_in   <= '0;
            a_ack    <= 1'b0;
            b_ack    <= 1'b0;
            busy     <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            a_ack <= 1'b0;
            b_ack <= 1'b0;
            ovf   <= disp_sel ? ovf_b : ovf_a;
            unique case (state)
                IDLE: begin
                    if (a_req || b_req) begin
                        src      <= grant_b ? SRC_B : SRC_A;
                        bcd_in   <= clamp_val(sel_val);
                        ovf_src  <= (sel_val > BCD_MAX);
                        wait_cnt <= 4'(CONV_WAIT);
                        busy     <= 1'b1;
                        state    <= CONV;
                        if (a_req && b_req) begin
                            rr_b <= ~rr_b;
                        end
                    end
                end
                CONV: begin
                    // Ack is raised here so it is high for exactly the CAPT cycle.
                    if (wait_cnt <= 4'd1) begin
                        state <= CAPT;
                        a_ack <= (src == SRC_A);
                        b_ack <= (src == SRC_B);
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                CAPT: begin
                    if (src == SRC_A) begin
                        dig_a <= {cv_thousands, cv_hundreds, cv_tens, cv_ones};
                        ovf_a <= ovf_src;
                    end else begin
                        dig_b <= {cv_thousands, cv_hundreds, cv_tens, cv_ones};
                        ovf_b <= ovf_src;
                    end
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    digit_scan #(
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK       (BLANK)
    ) u_scan (
        .clk   (clk),
        .rst   (rst),
        .word  (show_word),
        .an    (an),
        .digit (digit)
    );

endmodule

// File: tb/tb_bcd_share_scheduler.sv
// Directed bench for bcd_share_scheduler: one blanking instance (CONV_WAIT=1)
// and one non-blanking instance (CONV_WAIT=4), both with a fast scan.
module tb_bcd_share_scheduler;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rst2;
    logic [13:0] a_val, b_val;
    logic        a_req, b_req, a_req2, b_req2;
    logic        disp_sel, disp_sel2;

    logic        a_ack, b_ack, busy, ovf;
    logic [13:0] bcd_in;
    logic [3:0]  an, digit;
    logic [15:0] cvw;

    logic        a_ack2, b_ack2, busy2, ovf2;
    logic [13:0] bcd_in2;
    logic [3:0]  an2, digit2;
    logic [15:0] cvw2;

    int checks   = 0;
    int failures = 0;

    // Behavioural stand-in for the shared combinational converter.
    function automatic logic [15:0] to_bcd(input logic [13:0] v);
        int unsigned x;
        x = 32'(v);
        return {4'((x / 1000) % 10), 4'((x / 100) % 10), 4'((x / 10) % 10), 4'(x % 10)};
    endfunction

    assign cvw  = to_bcd(bcd_in);
    assign cvw2 = to_bcd(bcd_in2);

    bcd_share_scheduler #(.CONV_WAIT(1), .REFRESH_DIV(2), .BLANK(1)) dut (
        .clk(clk), .rst(rst),
        .a_val(a_val), .a_req(a_req), .a_ack(a_ack),
        .b_val(b_val), .b_req(b_req), .b_ack(b_ack),
        .disp_sel(disp_sel), .bcd_in(bcd_in),
        .cv_ones(cvw[3:0]), .cv_tens(cvw[7:4]),
        .cv_hundreds(cvw[11:8]), .cv_thousands(cvw[15:12]),
        .busy(busy), .ovf(ovf), .an(an), .digit(digit)
    );

    bcd_share_scheduler #(.CONV_WAIT(4), .REFRESH_DIV(2), .BLANK(0)) dut2 (
        .clk(clk), .rst(rst2),
        .a_val(a_val), .a_req(a_req2), .a_ack(a_ack2),
        .b_val(b_val), .b_req(b_req2), .b_ack(b_ack2),
        .disp_sel(disp_sel2), .bcd_in(bcd_in2),
        .cv_ones(cvw2[3:0]), .cv_tens(cvw2[7:4]),
        .cv_hundreds(cvw2[11:8]), .cv_thousands(cvw2[15:12]),
        .busy(busy2), .ovf(ovf2), .an(an2), .digit(digit2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Watch a full scan round; every lit anode must carry the right nibble.
    task automatic scan_check(input bit inst2, input string tag,
                              input logic [15:0] exp_word, input logic [3:0] exp_mask);
        logic [3:0] seen;
        logic [3:0] a_s, d_s, one_hot;
        logic [15:0] ew;
        seen = 4'b0000;
        ew   = exp_word;
        for (int i = 0; i < 12; i++) begin
            tick();
            a_s = inst2 ? an2 : an;
            d_s = inst2 ? digit2 : digit;
            if (a_s == 4'b1111) begin
                check_eq({tag, "_blank"}, 32'(d_s), 32'd0);
            end else begin
                for (int k = 0; k < 4; k++) begin
                    one_hot = 4'b0001 << k;
                    if (a_s == ~one_hot) begin
                        seen[k] = 1'b1;
                        check_eq({tag, "_dig"}, 32'(d_s), 32'(ew[k*4 +: 4]));
                    end
                end
            end
        end
        check_eq({tag, "_mask"}, 32'(seen), 32'(exp_mask));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int ta0, ta1, tb0, na, nb, t2, acks;
        rst = 1'b1; rst2 = 1'b1;
        a_val = '0; b_val = '0;
        a_req = 1'b0; b_req = 1'b0; a_req2 = 1'b0; b_req2 = 1'b0;
        disp_sel = 1'b0; disp_sel2 = 1'b0;
        tick();
        tick();
        check_eq("rst_an", 32'(an), 32'hF);
        check_eq("rst_digit", 32'(digit), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_a_ack", 32'(a_ack), 32'd0);
        check_eq("rst_b_ack", 32'(b_ack), 32'd0);
        check_eq("rst_bcd_in", 32'(bcd_in), 32'd0);
        check_eq("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0; rst2 = 1'b0;

        // Single A request
        a_val = 14'd1234; a_req = 1'b1;
        tick();
        check_eq("a_bcd_in", 32'(bcd_in), 32'd1234);
        check_eq("a_busy", 32'(busy), 32'd1);
        check_eq("a_ack_early", 32'(a_ack), 32'd0);
        a_req = 1'b0;
        tick();
        check_eq("a_ack_pulse", 32'(a_ack), 32'd1);
        check_eq("a_no_b_ack", 32'(b_ack), 32'd0);
        tick();
        check_eq("a_ack_drop", 32'(a_ack), 32'd0);
        check_eq("a_idle_busy", 32'(busy), 32'd0);
        scan_check(1'b0, "a1234", 16'h1234, 4'b1111);
        check_eq("a1234_ovf", 32'(ovf), 32'd0);

        // Both requesting: grants alternate A, B, A
        a_val = 14'd5; b_val = 14'd77; a_req = 1'b1; b_req = 1'b1;
        ta0 = -1; ta1 = -1; tb0 = -1; na = 0; nb = 0;
        for (int k = 0; k <= 9; k++) begin
            tick();
            if (a_ack) begin
                if (na == 0) ta0 = k; else ta1 = k;
                na++;
            end
            if (b_ack) begin
                if (nb == 0) tb0 = k;
                nb++;
            end
            if (k == 7) begin
                a_req = 1'b0; b_req = 1'b0;
            end
        end
        check_eq("rr_a_first", 32'(ta0), 32'd1);
        check_eq("rr_b_second", 32'(tb0), 32'd4);
        check_eq("rr_a_third", 32'(ta1), 32'd7);
        check_eq("rr_a_count", 32'(na), 32'd2);
        check_eq("rr_b_count", 32'(nb), 32'd1);
        scan_check(1'b0, "a5", 16'h0005, 4'b0001);
        disp_sel = 1'b1;
        scan_check(1'b0, "b77", 16'h0077, 4'b0011);
        check_eq("b77_ovf", 32'(ovf), 32'd0);

        // Clamp on B
        b_val = 14'd12000; b_req = 1'b1;
        tick();
        check_eq("clamp_bcd_in", 32'(bcd_in), 32'd9999);
        b_req = 1'b0;
        tick();
        check_eq("clamp_b_ack", 32'(b_ack), 32'd1);
        tick();
        scan_check(1'b0, "b9999", 16'h9999, 4'b1111);
        check_eq("clamp_ovf_b", 32'(ovf), 32'd1);
        disp_sel = 1'b0;
        tick();
        check_eq("clamp_ovf_a", 32'(ovf), 32'd0);

        // Value is sampled only at the grant edge
        a_val = 14'd7; a_req = 1'b1;
        tick();
        a_req = 1'b0; a_val = 14'd9000;
        tick();
        check_eq("hold_bcd_in", 32'(bcd_in), 32'd7);
        tick();
        scan_check(1'b0, "a7_blank", 16'h0007, 4'b0001);
        check_eq("a7_ovf", 32'(ovf), 32'd0);

        // No blanking, CONV_WAIT = 4 latency
        a_val = 14'd7; a_req2 = 1'b1;
        tick();
        a_req2 = 1'b0;
        t2 = -1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (a_ack2 && t2 < 0) t2 = k;
        end
        check_eq("wait4_ack_cycle", 32'(t2), 32'd4);
        scan_check(1'b1, "nb7", 16'h0007, 4'b1111);

        // Reset mid-conversion aborts the request and clears digits
        a_val = 14'd4321; a_req2 = 1'b1;
        tick();
        check_eq("abort_busy", 32'(busy2), 32'd1);
        check_eq("abort_bcd_in", 32'(bcd_in2), 32'd4321);
        a_req2 = 1'b0;
        tick();
        tick();
        rst2 = 1'b1;
        tick();
        rst2 = 1'b0;
        check_eq("abort_rst_busy", 32'(busy2), 32'd0);
        check_eq("abort_rst_bcd_in", 32'(bcd_in2), 32'd0);
        check_eq("abort_rst_an", 32'(an2), 32'hF);
        acks = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (a_ack2) acks++;
        end
        check_eq("abort_no_ack", 32'(acks), 32'd0);
        check_eq("abort_idle", 32'(busy2), 32'd0);
        scan_check(1'b1, "abort_clear", 16'h0000, 4'b1111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
